// File: rtl/rpu_pkg.sv
// Shared definitions for the push and pop RPUs: FSM encodings and node-word slot layout.
package rpu_pkg;

  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned PORT_W    = 2;
  localparam int unsigned FSM_W     = 2;

  localparam logic [FSM_W-1:0] ST_IDLE = 2'b00;
  localparam logic [FSM_W-1:0] ST_PUSH = 2'b11;
  localparam logic [FSM_W-1:0] ST_WB   = 2'b10;

  // A slot is {size, value}; the value sits in the low bits.
  function automatic int unsigned slot_w(input int unsigned ctw, input int unsigned mtw,
                                         input int unsigned ptw);
    return ctw + mtw + ptw;
  endfunction

  function automatic int unsigned size_off(input int unsigned mtw, input int unsigned ptw);
    return mtw + ptw;
  endfunction

endpackage

// File: rtl/rpu_min_sel.sv
// Picks the slot with the smallest sub-tree size; the lowest index wins ties.
module rpu_min_sel
  import rpu_pkg::*;
#(
  parameter int unsigned CTW = 10
) (
  input  logic [NUM_SLOTS*CTW-1:0] sizes_i,
  output logic [PORT_W-1:0]        port_o
);

  logic [CTW-1:0] s0, s1, s2, s3;
  logic [CTW-1:0] lo_min, hi_min;
  logic           lo_sel, hi_sel;

  assign s0 = sizes_i[0*CTW +: CTW];
  assign s1 = sizes_i[1*CTW +: CTW];
  assign s2 = sizes_i[2*CTW +: CTW];
  assign s3 = sizes_i[3*CTW +: CTW];

  // Strict less-than keeps the lower index on equal sizes at every level.
  assign lo_sel = (s1 < s0);
  assign hi_sel = (s3 < s2);
  assign lo_min = lo_sel ? s1 : s0;
  assign hi_min = hi_sel ? s3 : s2;

  always_comb begin
    port_o = {1'b0, lo_sel};
    if (hi_min < lo_min) begin
      port_o = {1'b1, hi_sel};
    end
  end

endmodule

// File: rtl/push_rpu.sv
// Push RPU: reads a 4-slot heap node, keeps the smaller value in the least-loaded slot, forwards the larger.
// Optional PUSH_RPU_FULL_CHECK_EN drops pushes into a saturated slot and pulses o_overflow.
module push_rpu
  import rpu_pkg::*;
#(
  parameter int unsigned PTW = 16,
  parameter int unsigned MTW = 0,
  parameter int unsigned CTW = 10,
  parameter int unsigned ADW = 20
) (
  input  logic                            i_clk,
  input  logic                            i_arst_n,
  input  logic                            i_push,
  input  logic [MTW+PTW-1:0]              i_push_data,
  output logic                            o_push,
  output logic [MTW+PTW-1:0]              o_push_data,
  output logic                            o_read,
  input  logic [4*(CTW+MTW+PTW)-1:0]      i_read_data,
  output logic                            o_write,
  output logic [4*(CTW+MTW+PTW)-1:0]      o_write_data,
  input  logic [ADW-1:0]                  i_my_addr,
  output logic [ADW-1:0]                  o_child_addr,
  output logic [ADW-1:0]                  o_read_addr,
  output logic [ADW-1:0]                  o_write_addr,
  output logic [1:0]                      o_fsm,
  output logic                            o_overflow
);

  localparam int unsigned VW     = MTW + PTW;
  localparam int unsigned SW     = slot_w(CTW, MTW, PTW);
  localparam int unsigned SZ_OFF = size_off(MTW, PTW);

  logic [FSM_W-1:0]          fsm_q, fsm_d;
  logic [ADW-1:0]            addr_q, addr_d;
  logic [VW-1:0]             data_q, data_d;
  logic [NUM_SLOTS*CTW-1:0]  sizes;
  logic [PORT_W-1:0]         port;
  logic [CTW-1:0]            tgt_size, new_size;
  logic [VW-1:0]             tgt_val, keep_val, fwd_val;
  logic                      fwd, full;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      fsm_q  <= ST_IDLE;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  // A push may only be accepted outside ST_PUSH; ST_PUSH always retires to ST_WB.
  always_comb begin
    fsm_d  = fsm_q;
    addr_d = addr_q;
    data_d = data_q;
    case (fsm_q)
      ST_PUSH: fsm_d = ST_WB;
      default: begin
        if (i_push) begin
          fsm_d  = ST_PUSH;
          addr_d = i_my_addr;
          data_d = i_push_data;
        end else begin
          fsm_d  = ST_IDLE;
          addr_d = '0;
        end
      end
    endcase
  end

  assign o_read       = i_push & ((fsm_q == ST_IDLE) | (fsm_q == ST_WB));
  assign o_read_addr  = i_my_addr;
  assign o_write_addr = addr_q;
  assign o_fsm        = fsm_q;

  always_comb begin
    sizes = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      sizes[i*CTW +: CTW] = i_read_data[i*SW+SZ_OFF +: CTW];
    end
  end

  rpu_min_sel #(.CTW(CTW)) u_min_sel (
    .sizes_i (sizes),
    .port_o  (port)
  );

  always_comb begin
    tgt_size = '0;
    tgt_val  = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (port == PORT_W'(i)) begin
        tgt_size = i_read_data[i*SW+SZ_OFF +: CTW];
        tgt_val  = i_read_data[i*SW +: VW];
      end
    end
  end

`ifdef PUSH_RPU_FULL_CHECK_EN
  assign full = &tgt_size;
`else
  assign full = 1'b0;
`endif

  // Stored value wins ties so equal priorities keep their original position.
  always_comb begin
    fwd      = (tgt_size != '0);
    new_size = tgt_size + CTW'(1);
    keep_val = data_q;
    fwd_val  = tgt_val;
    if (fwd && !(data_q[PTW-1:0] < tgt_val[PTW-1:0])) begin
      keep_val = tgt_val;
      fwd_val  = data_q;
    end
  end

  always_comb begin
    o_write      = 1'b0;
    o_write_data = '0;
    o_push       = 1'b0;
    o_push_data  = '1;
    o_child_addr = '1;
    o_overflow   = 1'b0;
    if (fsm_q == ST_PUSH) begin
      o_child_addr = {addr_q[ADW-3:0], port};
      if (full) begin
        o_overflow = 1'b1;
      end else begin
        o_write      = 1'b1;
        o_write_data = i_read_data;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
          if (port == PORT_W'(i)) begin
            o_write_data[i*SW +: VW]         = keep_val;
            o_write_data[i*SW+SZ_OFF +: CTW] = new_size;
          end
        end
        if (fwd) begin
          o_push      = 1'b1;
          o_push_data = fwd_val;
        end
      end
    end
  end

endmodule

// File: doc/push_rpu.md
PUSH_RPU -- requirements
Module: push_rpu

Interface
REQ-001 SHALL have parameter PTW, default 16, meaning payload/priority width.
REQ-002 SHALL have parameter MTW, default 0, meaning metadata width.
REQ-003 SHALL have parameter CTW, default 10, meaning sub-tree counter width.
REQ-004 SHALL have parameter ADW, default 20, meaning node address width.
REQ-005 SHALL have port i_clk, input, 1, the single clock.
REQ-006 SHALL have port i_arst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port i_push, input, 1, push command from parent.
REQ-008 SHALL have port i_push_data, input, MTW+PTW, data pushed by parent.
REQ-009 SHALL have port o_push, output, 1, push command to child.
REQ-010 SHALL have port o_push_data, output, MTW+PTW, data forwarded to child.
REQ-011 SHALL have port o_read, output, 1, SRAM read strobe.
REQ-012 SHALL have port i_read_data, input, 4*(CTW+MTW+PTW), node word {size3,val3,...,size0,val0}.
REQ-013 SHALL have port o_write, output, 1, SRAM write strobe.
REQ-014 SHALL have port o_write_data, output, 4*(CTW+MTW+PTW), updated node word, same packing.
REQ-015 SHALL have ports i_my_addr input ADW, o_child_addr output ADW, o_read_addr output ADW, o_write_addr output ADW.
REQ-016 SHALL have port o_fsm, output, 2, current state.
REQ-017 SHALL have port o_overflow, output, 1, one-cycle pulse when a push is dropped.

Function
REQ-018 SHALL implement states ST_IDLE=2'b00, ST_PUSH=2'b11, ST_WB=2'b10.
REQ-019 Transitions SHALL be: IDLE/WB + i_push -> PUSH, latching i_my_addr; IDLE/WB without i_push -> IDLE, address cleared to 0; PUSH -> WB unconditionally.
REQ-020 o_read SHALL equal i_push & (fsm==IDLE | fsm==WB); o_read_addr SHALL equal i_my_addr.
REQ-021 o_write, o_push and o_push_data SHALL be valid combinationally in ST_PUSH, one cycle after the accepted i_push; o_write_addr SHALL be the latched address.
REQ-022 In ST_PUSH, the target port SHALL be the slot with the smallest size field, with the lowest index winning ties.
REQ-023 If the target size is 0: write i_push_data into that slot; size becomes 1; o_push=0; the other slots are unchanged.
REQ-024 If the target size is nonzero: compare the low PTW bits of i_push_data with those of the stored value. The smaller value (stored value on tie) stays in the slot. The larger value drives o_push_data with o_push=1. The size is incremented by 1.
REQ-025 o_child_addr SHALL equal 4*latched_addr + port in ST_PUSH and all ones otherwise.
REQ-026 Outside ST_PUSH: o_write=0, o_write_data=0, o_push=0, o_push_data=all ones.
REQ-027 Maximum issue rate SHALL be one push every 2 cycles; the write in ST_PUSH SHALL precede the next read in ST_WB, so a same-address back-to-back push sees updated data.
REQ-028 i_push asserted while in ST_PUSH SHALL be ignored (the parent must not issue it).

Reset
REQ-029 On i_arst_n low, asynchronously: fsm=ST_IDLE, latched address=0, o_overflow=0; this aborts any in-flight push with no write issued.
REQ-030 While in reset, o_write=0, o_push=0, o_push_data=all ones, o_child_addr=all ones, o_write_data=0.

Configuration
REQ-031 Macro PUSH_RPU_FULL_CHECK_EN defined: if the target size equals 2^CTW-1, then o_write=0, o_push=0 and o_overflow pulses for 1 cycle in ST_PUSH.
REQ-032 Macro PUSH_RPU_FULL_CHECK_EN undefined: o_overflow is tied to 0 and the size increment wraps modulo 2^CTW.

Structure
REQ-033 State encodings and the slot field offset/width constants SHALL live in the shared package rpu_pkg, which is also used by the pop RPU.
REQ-034 Min-size port selection SHALL be a sub-module rpu_min_sel (4 sizes in, 2-bit port out).

Verification
REQ-035 Empty node (all sizes 0), push 0x0010 -> slot0 = {1, 0x0010}, o_push=0, write at the cycle after o_read.
REQ-036 Sizes {3,2,2,5} (slot3..0), push 0x0005 into slot1 holding 0x0009 -> slot1 = {3, 0x0005}, o_push=1, o_push_data=0x0009, o_child_addr=4*addr+1.
REQ-037 Sizes all 1 with slot0 value 0x0004, push 0x0004 -> slot0 keeps 0x0004, size becomes 2, forward 0x0004 to child 4*addr+0.
REQ-038 i_push held high for 6 cycles at the same address -> fsm sequence IDLE,PUSH,WB,PUSH,WB,PUSH; each read returns the previous write.
REQ-039 Target size 1023 with CTW=10 -> with the macro defined: o_overflow=1, no write and no push; without it: size wraps to 0.
REQ-040 Reset asserted during ST_PUSH -> outputs return to the REQ-030 values immediately and fsm reads IDLE.
